psum_accumulator: RTL and testbench

- Sits directly downstream of the bottom fusion unit of a column and consumes its packed psum_fwd word.
- Splits the word into 1, 2 or 4 lanes according to the bit-width mode.
- Accumulates each lane over a programmable number of beats, with signed or unsigned arithmetic.
- Pushes each finished result into a small output FIFO, drained by a valid/ready handshake toward the writeback/quantise stage.

---
 rtl/fusion_pkg.sv | 41 ++++
 rtl/psum_result_fifo.sv | 71 +++++++
 rtl/psum_accumulator.sv | 227 ++++++++++++++++++++++
 tb/tb_psum_accumulator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fusion_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fusion_pkg
//  Description : Shared definitions for the column fusion / psum datapath:
//                bit-width mode encodings, lane-count helper, and the
//                accumulator FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package fusion_pkg;

    localparam logic [3:0] MODE_W8 = 4'b1000;
    localparam logic [3:0] MODE_W4 = 4'b0100;
    localparam logic [3:0] MODE_W2 = 4'b0010;
    localparam logic [3:0] MODE_W1 = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2
    } acc_state_t;

    // Only the four one-hot encodings are meaningful.
    function automatic logic mode_legal(input logic [3:0] mode);
        return (mode == MODE_W8) || (mode == MODE_W4) ||
               (mode == MODE_W2) || (mode == MODE_W1);
    endfunction

    // 8-bit mode uses the whole word as one lane; 2-bit and 1-bit encodings
    // both split it into four column-wide lanes.
    function automatic logic [2:0] lane_count(input logic [3:0] mode);
        logic [2:0] n;
        case (mode)
            MODE_W8: n = 3'd1;
            MODE_W4: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage : fusion_pkg
`default_nettype wire

// File: rtl/psum_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : psum_result_fifo
//  Description : Synchronous DEPTH-entry FIFO for finished accumulation
//                results. Head entry is presented combinationally.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                push, push_data  - write request and entry
//                pop, pop_data    - read request and head entry
//                full, empty      - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_result_fifo #(
    parameter int WIDTH = 196,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

endmodule : psum_result_fifo
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : psum_accumulator
//  Description : Splits the packed column psum word into 1/2/4 lanes,
//                accumulates each lane over acc_len beats (signed or
//                unsigned, wrapping, sticky overflow) and queues results in
//                an output FIFO drained by valid/ready.
//  Ports       : clk, rst                       - clock, sync reset
//                start, in_width, s_out, acc_len - job setup (IDLE only)
//                psum_valid/psum_ready/psum_in   - input beat stream
//                out_valid/out_ready/out_data,
//                out_lanes, out_ovf              - result stream
//                busy, cfg_err                   - status
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_accumulator
    import fusion_pkg::*;
#(
    parameter int COL_WIDTH = 11,
    parameter int ACC_WIDTH = 48,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             in_width,
    input  logic                   s_out,
    input  logic [15:0]            acc_len,
    input  logic                   psum_valid,
    output logic                   psum_ready,
    input  logic [4*COL_WIDTH-1:0] psum_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*ACC_WIDTH-1:0] out_data,
    output logic [2:0]             out_lanes,
    output logic                   out_ovf,
    output logic                   busy,
    output logic                   cfg_err
);

    localparam int IN_W    = 4 * COL_WIDTH;
    localparam int EXT_W   = (ACC_WIDTH > IN_W) ? ACC_WIDTH : IN_W;
    localparam int DATA_W  = 4 * ACC_WIDTH;
    localparam int ENTRY_W = DATA_W + 4;

    acc_state_t           state_q, state_d;
    logic [3:0]           mode_q, mode_d;
    logic                 sign_q, sign_d;
    logic [15:0]          len_q, len_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q [4];
    logic [ACC_WIDTH-1:0] acc_d [4];
    logic                 ovf_q, ovf_d;
    logic                 psum_ready_q, psum_ready_d;
    logic                 busy_q, busy_d;
    logic                 cfg_err_q, cfg_err_d;

    logic [ACC_WIDTH-1:0] lane_sum [4];
    logic [3:0]           lane_ovf;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_wdata, fifo_rdata;
    logic                 can_push;

    // ------------------------------------------------------------------
    // Lane slicing, extension and per-lane add with overflow detection
    // ------------------------------------------------------------------
    always_comb begin
        int                   lane_w;
        logic [2:0]           n_lanes;
        logic [EXT_W-1:0]     pad;
        logic [EXT_W-1:0]     aligned;
        logic [EXT_W-1:0]     ext;
        logic [ACC_WIDTH-1:0] addend;
        logic [ACC_WIDTH:0]   wide;

        case (mode_q)
            MODE_W8: lane_w = IN_W;
            MODE_W4: lane_w = 2 * COL_WIDTH;
            default: lane_w = COL_WIDTH;
        endcase
        n_lanes = lane_count(mode_q);

        for (int i = 0; i < 4; i++) begin
            pad = '0;
            pad[IN_W-1:0] = psum_in >> (i * lane_w);
            // Park the lane at the top so one right shift both drops the
            // neighbouring lanes and performs the sign/zero extension.
            aligned = pad << (EXT_W - lane_w);
            if (sign_q) begin
                ext = $signed(aligned) >>> (EXT_W - lane_w);
            end else begin
                ext = aligned >> (EXT_W - lane_w);
            end
            addend = (3'(i) < n_lanes) ? ext[ACC_WIDTH-1:0] : '0;

            wide        = {1'b0, acc_q[i]} + {1'b0, addend};
            lane_sum[i] = wide[ACC_WIDTH-1:0];
            if (sign_q) begin
                lane_ovf[i] = (acc_q[i][ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
                              (lane_sum[i][ACC_WIDTH-1] != acc_q[i][ACC_WIDTH-1]);
            end else begin
                lane_ovf[i] = wide[ACC_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM next-state
    // ------------------------------------------------------------------
    assign fifo_pop = out_ready & ~fifo_empty;
    assign can_push = ~fifo_full | fifo_pop;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        sign_d    = sign_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cfg_err_d = 1'b0;
        fifo_push = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_legal(in_width)) begin
                        mode_d  = in_width;
                        sign_d  = s_out;
                        len_d   = (acc_len == 16'd0) ? 16'd1 : acc_len;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                        state_d = ST_ACCUM;
                        for (int i = 0; i < 4; i++) begin
                            acc_d[i] = '0;
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (psum_valid && psum_ready_q) begin
                    acc_d = lane_sum;
                    ovf_d = ovf_q | (|lane_ovf);
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == len_q - 16'd1) begin
                        if (can_push) begin
                            fifo_push = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            state_d   = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (can_push) begin
                    fifo_push = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // acc_d holds the final sum both on the last beat and while flushing.
        fifo_wdata = {ovf_d, lane_count(mode_q), acc_d[3], acc_d[2], acc_d[1], acc_d[0]};

        psum_ready_d = (state_d == ST_ACCUM);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_W8;
            sign_q       <= 1'b0;
            len_q        <= 16'd1;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            psum_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            sign_q       <= sign_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            psum_ready_q <= psum_ready_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            acc_q        <= acc_d;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    psum_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign psum_ready = psum_ready_q;
    assign busy       = busy_q;
    assign cfg_err    = cfg_err_q;
    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_rdata[DATA_W-1:0];
    assign out_lanes  = fifo_rdata[DATA_W+2:DATA_W];
    assign out_ovf    = fifo_rdata[ENTRY_W-1];

endmodule : psum_accumulator
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_accumulator
//  Description : Self-checking bench for psum_accumulator. Expected results
//                are computed from lane arithmetic on integers and queued at
//                job issue; a monitor pops them as the DUT presents results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_accumulator;
    import fusion_pkg::*;

    localparam int C  = 11;
    localparam int AW = 48;

    typedef struct packed {
        logic          ovf;
        logic [2:0]    lanes;
        logic [4*AW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    in_width;
    logic          s_out;
    logic [15:0]   acc_len;
    logic          psum_valid;
    logic          psum_ready;
    logic [4*C-1:0] psum_in;
    logic          out_valid;
    logic          out_ready;
    logic [4*AW-1:0] out_data;
    logic [2:0]    out_lanes;
    logic          out_ovf;
    logic          busy;
    logic          cfg_err;

    // Narrow-accumulator instance for wrap/overflow behaviour.
    logic          s_start;
    logic          s_psum_valid;
    logic          s_psum_ready;
    logic [4*C-1:0] s_psum_in;
    logic          s_out_valid;
    logic [47:0]   s_out_data;
    logic [2:0]    s_out_lanes;
    logic          s_out_ovf;
    logic          s_busy;
    logic          s_cfg_err;

    logic ready_ctl, rnd_ready, use_rnd;
    assign out_ready = use_rnd ? rnd_ready : ready_ctl;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    psum_accumulator #(.COL_WIDTH(C), .ACC_WIDTH(AW), .DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_width(in_width), .s_out(s_out),
        .acc_len(acc_len), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .psum_in(psum_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lanes(out_lanes), .out_ovf(out_ovf),
        .busy(busy), .cfg_err(cfg_err)
    );

    psum_accumulator #(.COL_WIDTH(C), .ACC_WIDTH(12), .DEPTH(4)) u_dut12 (
        .clk(clk), .rst(rst), .start(s_start), .in_width(MODE_W2), .s_out(1'b0),
        .acc_len(16'd3), .psum_valid(s_psum_valid), .psum_ready(s_psum_ready),
        .psum_in(s_psum_in), .out_valid(s_out_valid), .out_ready(1'b1),
        .out_data(s_out_data), .out_lanes(s_out_lanes), .out_ovf(s_out_ovf),
        .busy(s_busy), .cfg_err(s_cfg_err)
    );

    task automatic check(input string name, input logic [4*AW-1:0] act, input logic [4*AW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: integer lane sums, wrapped into the accumulator's range,
    // with overflow whenever an exact step result leaves that range.
    function automatic exp_t model(input logic [3:0] mode, input bit sgn, input logic [4*C-1:0] beats[$]);
        exp_t   e;
        int     n, lw;
        longint acc [4];
        longint v, s;
        longint span = longint'(1) << AW;
        longint smax = (longint'(1) << (AW-1)) - 1;
        longint smin = -(longint'(1) << (AW-1));
        bit     ovf = 0;
        n  = (mode == MODE_W8) ? 1 : (mode == MODE_W4) ? 2 : 4;
        lw = 4 * C / n;
        for (int i = 0; i < 4; i++) acc[i] = 0;
        foreach (beats[k]) begin
            for (int i = 0; i < n; i++) begin
                v = (longint'(beats[k]) >> (i*lw)) & ((longint'(1) << lw) - 1);
                if (sgn && ((v >> (lw-1)) & 1) == 1) v = v - (longint'(1) << lw);
                s = acc[i] + v;
                if (sgn) begin
                    if (s > smax) begin ovf = 1; s = s - span; end
                    if (s < smin) begin ovf = 1; s = s + span; end
                end else if (s >= span) begin
                    ovf = 1; s = s - span;
                end
                acc[i] = s;
            end
        end
        e.data = '0;
        for (int i = 0; i < 4; i++) e.data[i*AW +: AW] = acc[i][AW-1:0];
        e.lanes = 3'(n);
        e.ovf   = ovf;
        return e;
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin @(posedge clk); #1; t++; end
        check("wait_idle", {191'd0, busy}, '0);
    endtask

    task automatic do_start(input logic [3:0] mode, input bit sgn, input logic [15:0] len);
        in_width = mode; s_out = sgn; acc_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [4*C-1:0] val, input bit gaps);
        int  t = 0;
        bit  acc_ok = 0;
        if (gaps && ($urandom_range(0, 2) == 0)) begin
            psum_valid = 1'b0; @(posedge clk); #1;
        end
        psum_valid = 1'b1; psum_in = val;
        while (!acc_ok && t < 200) begin
            @(negedge clk); acc_ok = psum_ready;
            @(posedge clk); #1; t++;
        end
        psum_valid = 1'b0;
        check("beat_accepted", {191'd0, acc_ok}, 1);
    endtask

    task automatic run_job(input logic [3:0] mode, input bit sgn, input logic [15:0] len,
                           input bit use_fixed, input logic [4*C-1:0] fixed, input bit gaps);
        logic [4*C-1:0] bq[$];
        logic [63:0]    r;
        int nb = (len == 0) ? 1 : int'(len);
        for (int k = 0; k < nb; k++) begin
            r = {$urandom(), $urandom()};
            bq.push_back(use_fixed ? fixed : r[4*C-1:0]);
        end
        sb.push_back(model(mode, sgn, bq));
        wait_idle();
        do_start(mode, sgn, len);
        for (int k = 0; k < nb; k++) send_beat(bq[k], gaps);
    endtask

    // Monitor: compare every handshaken result with the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL sb_unexpected: got %h expected no result", out_data);
                end else begin
                    e = sb.pop_front();
                    check("sb_data",  out_data, e.data);
                    check("sb_lanes", {189'd0, out_lanes}, {189'd0, e.lanes});
                    check("sb_ovf",   {191'd0, out_ovf},   {191'd0, e.ovf});
                end
            end
        end
    end

    initial begin
        forever begin @(posedge clk); #1; rnd_ready = 1'($urandom_range(0, 1)); end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] m;
        int t;
        rst = 1'b1; start = 0; in_width = MODE_W8; s_out = 0; acc_len = 1;
        psum_valid = 0; psum_in = '0; ready_ctl = 1; use_rnd = 0; rnd_ready = 0;
        s_start = 0; s_psum_valid = 0; s_psum_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_out_valid",  {191'd0, out_valid},  '0);
        check("rst_busy",       {191'd0, busy},       '0);
        check("rst_psum_ready", {191'd0, psum_ready}, '0);
        check("rst_cfg_err",    {191'd0, cfg_err},    '0);
        check("rst_out_data",   out_data, '0);
        check("rst_out_meta",   {188'd0, out_lanes, out_ovf}, '0);

        // 2-bit unsigned, three beats of {4,3,2,1}
        run_job(MODE_W2, 0, 16'd3, 1, {11'd4, 11'd3, 11'd2, 11'd1}, 0);
        check("t1_valid_after_last", {191'd0, out_valid}, 1);
        check("t1_data",  out_data, {48'd12, 48'd9, 48'd6, 48'd3});
        check("t1_lanes", {189'd0, out_lanes}, 4);
        @(posedge clk); #1;
        check("t1_valid_one_cycle", {191'd0, out_valid}, '0);

        // 4-bit signed: lane0 = -1, lane1 = 5, two beats
        run_job(MODE_W4, 1, 16'd2, 1, {22'd5, 22'h3FFFFF}, 0);
        check("t2_data", out_data, {48'd0, 48'd0, 48'd10, 48'hFFFF_FFFF_FFFE});
        check("t2_lanes", {189'd0, out_lanes}, 2);

        // 12-bit accumulator wrap with unsigned overflow
        s_start = 1; @(posedge clk); #1; s_start = 0;
        for (int k = 0; k < 3; k++) begin
            s_psum_valid = 1; s_psum_in = {33'd0, 11'h7FF};
            @(posedge clk); #1;
        end
        s_psum_valid = 0;
        check("t3_valid", {191'd0, s_out_valid}, 1);
        check("t3_data",  {144'd0, s_out_data}, {144'd0, 36'd0, 12'h7FD});
        check("t3_ovf",   {191'd0, s_out_ovf}, 1);

        // FIFO full: four results queue, fifth job stalls in FLUSH
        ready_ctl = 0;
        for (int j = 0; j < 5; j++) run_job(MODE_W8, j[0], 16'd1, 0, '0, 0);
        check("t4_flush_ready", {191'd0, psum_ready}, '0);
        check("t4_flush_busy",  {191'd0, busy}, 1);
        ready_ctl = 1;
        @(posedge clk); #1;
        check("t4_idle_after_pop", {191'd0, busy}, '0);
        t = 0;
        while (sb.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
        check("t4_drained", 192'(sb.size()), '0);

        // Illegal mode, then zero length
        wait_idle();
        do_start(4'b0011, 0, 16'd4);
        check("t5_cfg_err_pulse", {191'd0, cfg_err}, 1);
        check("t5_busy_low",      {191'd0, busy}, '0);
        @(posedge clk); #1;
        check("t5_cfg_err_clear", {191'd0, cfg_err}, '0);
        run_job(MODE_W1, 1, 16'd0, 0, '0, 0);
        check("t5_len0_done", {191'd0, busy}, '0);

        // Reset mid-job with two results pending
        ready_ctl = 0;
        run_job(MODE_W2, 0, 16'd1, 0, '0, 0);
        run_job(MODE_W4, 0, 16'd1, 0, '0, 0);
        do_start(MODE_W2, 0, 16'd3);
        send_beat(44'h123_4567_89AB, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_out_valid", {191'd0, out_valid},  '0);
        check("t6_busy",      {191'd0, busy},       '0);
        check("t6_ready",     {191'd0, psum_ready}, '0);
        rst = 1'b0;
        sb.delete();
        ready_ctl = 1;
        run_job(MODE_W2, 0, 16'd3, 0, '0, 0);

        // Randomized jobs with random back-pressure and input gaps
        use_rnd = 1;
        for (int j = 0; j < 40; j++) begin
            case ($urandom_range(0, 3))
                0: m = MODE_W8;
                1: m = MODE_W4;
                2: m = MODE_W2;
                default: m = MODE_W1;
            endcase
            run_job(m, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 6)), 0, '0, 1);
        end
        use_rnd = 0; ready_ctl = 1;
        t = 0;
        while (sb.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
        check("final_drained", 192'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_psum_accumulator
`default_nettype wire
